// File: rtl/occupancy_counter.sv
// Debounced entry/exit head counter: two active-low buttons feed a saturating
// 0..MAX_COUNT occupancy count kept both in binary and as a BCD digit pair.
module occupancy_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_COUNT       = 99
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Clear,
  input  logic       EnterIn,
  input  logic       ExitIn,
  output logic [3:0] PersonDigit1,
  output logic [3:0] PersonDigit0,
  output logic [6:0] CountBin,
  output logic       Empty,
  output logic       Full,
  output logic       Reject
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] MAX = 7'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;

  // Channel 0 = entry, channel 1 = exit.
  logic [1:0]    buttons;
  logic [1:0]    sync1, sync2;
  logic [1:0]    press_event;
  db_state_t     state [2];
  logic [CW-1:0] cnt   [2];

  assign buttons = {ExitIn, EnterIn};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1       <= '1;
      sync2       <= '1;
      press_event <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        state[ch] <= IDLE;
        cnt[ch]   <= '0;
      end
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        press_event[ch] <= 1'b0;
        case (state[ch])
          IDLE:
            if (!sync2[ch]) begin
              state[ch] <= PRESS_WAIT;
              cnt[ch]   <= CW'(1);
            end
          PRESS_WAIT:
            if (sync2[ch]) begin
              state[ch] <= IDLE;
              cnt[ch]   <= '0;
            end else begin
              cnt[ch] <= cnt[ch] + CW'(1);
              // Event fires on the same edge the counter reaches the threshold.
              if (cnt[ch] == LAST) begin
                state[ch]       <= PRESSED;
                press_event[ch] <= 1'b1;
              end
            end
          PRESSED:
            if (sync2[ch]) begin
              state[ch] <= RELEASE_WAIT;
              cnt[ch]   <= CW'(1);
            end
          RELEASE_WAIT:
            if (!sync2[ch]) begin
              state[ch] <= PRESSED;
              cnt[ch]   <= '0;
            end else if (cnt[ch] == LAST) begin
              state[ch] <= IDLE;
              cnt[ch]   <= '0;
            end else begin
              cnt[ch] <= cnt[ch] + CW'(1);
            end
          default: begin
            state[ch] <= IDLE;
            cnt[ch]   <= '0;
          end
        endcase
      end
    end
  end

  // BCD digits track the binary count in the same edge via carry/borrow.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      CountBin     <= '0;
      PersonDigit1 <= '0;
      PersonDigit0 <= '0;
      Reject       <= 1'b0;
    end else begin
      Reject <= 1'b0;
      if (Clear) begin
        CountBin     <= '0;
        PersonDigit1 <= '0;
        PersonDigit0 <= '0;
      end else if (Enable && press_event == 2'b01) begin
        if (CountBin < MAX) begin
          CountBin <= CountBin + 7'd1;
          if (PersonDigit0 == 4'd9) begin
            PersonDigit0 <= '0;
            PersonDigit1 <= PersonDigit1 + 4'd1;
          end else begin
            PersonDigit0 <= PersonDigit0 + 4'd1;
          end
        end else begin
          Reject <= 1'b1;
        end
      end else if (Enable && press_event == 2'b10) begin
        if (CountBin != '0) begin
          CountBin <= CountBin - 7'd1;
          if (PersonDigit0 == 4'd0) begin
            PersonDigit0 <= 4'd9;
            PersonDigit1 <= PersonDigit1 - 4'd1;
          end else begin
            PersonDigit0 <= PersonDigit0 - 4'd1;
          end
        end else begin
          Reject <= 1'b1;
        end
      end
    end
  end

  assign Empty = (CountBin == '0);
  assign Full  = (CountBin == MAX);

endmodule

// File: tb/tb_occupancy_counter.sv
// Directed bench for occupancy_counter with a short debounce window (4 cycles).
module tb_occupancy_counter;

  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Reset, Enable, Clear, EnterIn, ExitIn;
  logic [3:0] PersonDigit1, PersonDigit0;
  logic [6:0] CountBin;
  logic       Empty, Full, Reject;

  int n_cmp = 0;
  int n_err = 0;

  occupancy_counter #(.DEBOUNCE_CYCLES(D), .MAX_COUNT(99)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Clear(Clear),
    .EnterIn(EnterIn), .ExitIn(ExitIn),
    .PersonDigit1(PersonDigit1), .PersonDigit0(PersonDigit0),
    .CountBin(CountBin), .Empty(Empty), .Full(Full), .Reject(Reject)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One full press/release; returns number of cycles Reject was seen high.
  task automatic press(input logic ent, input logic ext, output int rej);
    rej = 0;
    EnterIn = ~ent;
    ExitIn  = ~ext;
    repeat (12) begin tick(); if (Reject) rej++; end
    EnterIn = 1'b1;
    ExitIn  = 1'b1;
    repeat (10) begin tick(); if (Reject) rej++; end
  endtask

  task automatic presses(input logic ent, input int n);
    int r;
    for (int i = 0; i < n; i++) press(ent, ~ent, r);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Enable = 1'b1; Clear = 1'b0; EnterIn = 1'b1; ExitIn = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({CountBin, PersonDigit1, PersonDigit0, Empty, Full, Reject} !== {7'd0, 4'd0, 4'd0, 3'b100}) begin
      n_err++;
      $display("FAIL reset: count=%0d digits=%0d/%0d E=%b F=%b R=%b, want 0 0/0 E=1 F=0 R=0",
               CountBin, PersonDigit1, PersonDigit0, Empty, Full, Reject);
    end
  endtask

  task automatic test_glitch();
    EnterIn = 1'b0;
    repeat (3) tick();
    EnterIn = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if (CountBin !== 7'd0) begin
      n_err++;
      $display("FAIL glitch: count=%0d want 0", CountBin);
    end
  endtask

  task automatic test_latency();
    int first;
    first = -1;
    EnterIn = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (first < 0 && CountBin != 7'd0) first = k;
    end
    EnterIn = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (first !== D + 2) begin
      n_err++;
      $display("FAIL latency: count changed at edge E+%0d want E+%0d", first, D + 2);
    end
    n_cmp++;
    if ({CountBin, Empty} !== {7'd1, 1'b0}) begin
      n_err++;
      $display("FAIL single_inc: count=%0d Empty=%b want 1 Empty=0", CountBin, Empty);
    end
  endtask

  task automatic test_bcd();
    int r;
    presses(1'b1, 11);
    n_cmp++;
    if ({CountBin, PersonDigit1, PersonDigit0} !== {7'd12, 4'd1, 4'd2}) begin
      n_err++;
      $display("FAIL bcd_12: %0d (%0d/%0d) want 12 (1/2)", CountBin, PersonDigit1, PersonDigit0);
    end
    press(1'b0, 1'b1, r);
    n_cmp++;
    if ({CountBin, PersonDigit1, PersonDigit0} !== {7'd11, 4'd1, 4'd1}) begin
      n_err++;
      $display("FAIL bcd_11: %0d (%0d/%0d) want 11 (1/1)", CountBin, PersonDigit1, PersonDigit0);
    end
    presses(1'b0, 2);
    n_cmp++;
    if ({CountBin, PersonDigit1, PersonDigit0} !== {7'd9, 4'd0, 4'd9}) begin
      n_err++;
      $display("FAIL bcd_borrow: %0d (%0d/%0d) want 9 (0/9)", CountBin, PersonDigit1, PersonDigit0);
    end
  endtask

  task automatic test_saturation();
    int r;
    presses(1'b1, 90);
    n_cmp++;
    if ({CountBin, PersonDigit1, PersonDigit0, Full} !== {7'd99, 4'd9, 4'd9, 1'b1}) begin
      n_err++;
      $display("FAIL fill_99: %0d (%0d/%0d) Full=%b want 99 (9/9) Full=1",
               CountBin, PersonDigit1, PersonDigit0, Full);
    end
    press(1'b1, 1'b0, r);
    n_cmp++;
    if ({CountBin, Full} !== {7'd99, 1'b1} || r !== 1) begin
      n_err++;
      $display("FAIL sat_top: count=%0d Full=%b rejects=%0d want 99 Full=1 rejects=1", CountBin, Full, r);
    end
    presses(1'b0, 62);
    n_cmp++;
    if ({CountBin, PersonDigit1, PersonDigit0} !== {7'd37, 4'd3, 4'd7}) begin
      n_err++;
      $display("FAIL down_37: %0d (%0d/%0d) want 37 (3/7)", CountBin, PersonDigit1, PersonDigit0);
    end
  endtask

  task automatic test_clear();
    int r;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    n_cmp++;
    if ({CountBin, PersonDigit1, PersonDigit0, Empty} !== {7'd0, 4'd0, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL clear: %0d (%0d/%0d) Empty=%b want 0 (0/0) Empty=1",
               CountBin, PersonDigit1, PersonDigit0, Empty);
    end
    press(1'b0, 1'b1, r);
    n_cmp++;
    if (CountBin !== 7'd0 || r !== 1) begin
      n_err++;
      $display("FAIL sat_bottom: count=%0d rejects=%0d want 0 rejects=1", CountBin, r);
    end
  endtask

  task automatic test_simultaneous();
    int r;
    presses(1'b1, 1);
    press(1'b1, 1'b1, r);
    n_cmp++;
    if (CountBin !== 7'd1 || r !== 0) begin
      n_err++;
      $display("FAIL both: count=%0d rejects=%0d want 1 rejects=0", CountBin, r);
    end
  endtask

  task automatic test_enable();
    int r;
    r = 0;
    Enable = 1'b0;
    EnterIn = 1'b0;
    repeat (12) begin tick(); if (Reject) r++; end
    Enable = 1'b1;
    repeat (12) begin tick(); if (Reject) r++; end
    EnterIn = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (CountBin !== 7'd1 || r !== 0) begin
      n_err++;
      $display("FAIL enable: count=%0d rejects=%0d want 1 rejects=0", CountBin, r);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    first = -1;
    EnterIn = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if ({CountBin, Empty} !== {7'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid: count=%0d Empty=%b want 0 Empty=1", CountBin, Empty);
    end
    for (int k = 1; k < 15; k++) begin
      tick();
      if (first < 0 && CountBin != 7'd0) first = k;
    end
    EnterIn = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (first !== D + 3 || CountBin !== 7'd1) begin
      n_err++;
      $display("FAIL reset_rearm: changed at R+%0d count=%0d want R+%0d count=1", first, CountBin, D + 3);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latency();
    test_bcd();
    test_saturation();
    test_clear();
    test_simultaneous();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
- Debounces two active-low push-button inputs (entry and exit) and keeps a saturating 2-digit BCD head count of room occupants.
- Directly upstream of the display/temperature top level. Its BCD digits drive the person-count seven-segment pair and the optimum-temperature lookup. Its Empty flag drives the "OFF" display decision.
- Replaces the unsynchronised, undebounced person add/remove logic.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable sync'd cycles required to accept a level change (10 ms at 50 MHz); must be >= 2
MAX_COUNT, 99, saturation ceiling of the head count (binary value, <= 99)

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
Enable  input  1  1 = accepted presses update the count; 0 = presses are consumed and discarded
Clear  input  1  synchronous count clear, active-high, level
EnterIn  input  1  entry button, active-low, asynchronous to Clock
ExitIn  input  1  exit button, active-low, asynchronous to Clock
PersonDigit1  output  4  BCD tens digit of count
PersonDigit0  output  4  BCD ones digit of count
CountBin  output  7  binary count, 0..MAX_COUNT
Empty  output  1  1 when count == 0
Full  output  1  1 when count == MAX_COUNT
Reject  output  1  one-cycle pulse when an accepted press was dropped by saturation

Behaviour:
- Reset (Clock edge with Reset=1) has priority over all other inputs and takes effect regardless of Enable or Clear. It sets:
  - CountBin=0, PersonDigit1=0, PersonDigit0=0, Empty=1, Full=0 (MAX_COUNT>0), Reject=0.
  - Sync flops of both channels to 1 (released).
  - Both debounce FSMs to IDLE, debounce counters to 0.
- Synchronisation: each button passes through 2 flops. Inside the block, press = synchronised level 0.
- Per-channel debounce FSM, with a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits:
  - IDLE: sync'd level 0 -> PRESS_WAIT with counter=1. Otherwise stay.
  - PRESS_WAIT: level 0 -> counter++. When counter reaches DEBOUNCE_CYCLES -> PRESSED, with a one-cycle internal event in that same cycle. Level 1 -> IDLE, counter=0 (glitch rejected, no event).
  - PRESSED: level 1 -> RELEASE_WAIT with counter=1. Otherwise stay. A held button generates exactly one event.
  - RELEASE_WAIT: level 1 -> counter++. When counter reaches DEBOUNCE_CYCLES -> IDLE. Level 0 -> PRESSED, counter=0, no new event.
- Latency: if EnterIn is first sampled low at edge E and held, the count changes at edge E+DEBOUNCE_CYCLES+2. That is: 2 sync cycles, plus DEBOUNCE_CYCLES-1 further cycles to confirm, plus 1 register update.
- Count update is registered and evaluated each cycle in this priority order:
  1. Clear=1: count=0, Reject=0, events discarded.
  2. Enable=0: count held, events discarded, Reject=0.
  3. Enter event and exit event in the same cycle: net zero, count held, Reject=0.
  4. Enter event only: if count < MAX_COUNT then count+1, otherwise count held and Reject=1 for one cycle.
  5. Exit event only: if count > 0 then count-1, otherwise count held and Reject=1 for one cycle.
- The debounce FSMs keep running while Clear=1 or Enable=0. A button held across Enable rising edge produces no event.
- Output derivation:
  - PersonDigit1/PersonDigit0 are registered BCD values updated in the same edge as CountBin. Either maintain them as BCD with ones-digit wrap 9->0 (carry/borrow into tens), or convert registered CountBin (tens = CountBin/10). Both paths must match at every cycle; the digits never lag CountBin.
  - Empty and Full are combinational from the registered count, so they are coincident with it.
- No wrap-around at any boundary: saturation only.

Test Plan:
- Reset, then no stimulus -> CountBin=0, digits 0/0, Empty=1, Full=0, Reject=0.
- DEBOUNCE_CYCLES=4: EnterIn low 3 cycles then high -> no count change. EnterIn low 20 cycles -> count 1 exactly at edge E+6, single increment, Empty=0.
- Twelve clean enter presses from 0 -> CountBin=12, PersonDigit1=1, PersonDigit0=2. Then one exit -> 11 (digits 1/1). Repeat exits across 10 -> 09 (digits 0/9) with correct borrow.
- Preload to 99 with MAX_COUNT=99, then press enter -> count stays 99, Full=1, one Reject pulse. At count 0, press exit -> stays 0, one Reject pulse.
- Enter and exit pressed together so both events land on the same cycle -> count unchanged, Reject=0. Enable=0 during a press -> count unchanged, and the held button gives no event after Enable returns to 1.
- Clear=1 at count 37 -> 0 next edge, Empty=1. Reset asserted mid PRESS_WAIT -> FSM to IDLE, count 0, no event once Reset is released while the button is still held, until DEBOUNCE_CYCLES more cycles elapse.
